// File: rtl/memory_control_if.sv
// Bus bundle between memory_control and its RAM, Fetcher, LSB and ROB neighbours.
interface memory_control_if;
  logic        rdy_in;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  logic        enable_from_fetcher;
  logic [31:0] address_from_fetcher;
  logic        reset_from_fetcher;
  logic        one_inst_finish_to_fetcher;
  logic        end_to_fetcher;
  logic [31:0] inst_to_fetcher;

  logic        enable_from_lsb;
  logic        wr_flag_from_lsb;
  logic [31:0] address_from_lsb;
  logic [2:0]  size_from_lsb;
  logic [31:0] data_from_lsb;
  logic        rollback_flag_from_rob;
  logic        end_to_lsb;
  logic [31:0] data_to_lsb;

  modport slave (
    input  rdy_in, mem_din, io_buffer_full,
    input  enable_from_fetcher, address_from_fetcher, reset_from_fetcher,
    input  enable_from_lsb, wr_flag_from_lsb, address_from_lsb, size_from_lsb,
    input  data_from_lsb, rollback_flag_from_rob,
    output mem_dout, mem_a, mem_wr,
    output one_inst_finish_to_fetcher, end_to_fetcher, inst_to_fetcher,
    output end_to_lsb, data_to_lsb
  );

  modport master (
    output rdy_in, mem_din, io_buffer_full,
    output enable_from_fetcher, address_from_fetcher, reset_from_fetcher,
    output enable_from_lsb, wr_flag_from_lsb, address_from_lsb, size_from_lsb,
    output data_from_lsb, rollback_flag_from_rob,
    input  mem_dout, mem_a, mem_wr,
    input  one_inst_finish_to_fetcher, end_to_fetcher, inst_to_fetcher,
    input  end_to_lsb, data_to_lsb
  );
endinterface

// File: rtl/memory_control.sv
// Arbiter and byte-serial sequencer between the 8-bit RAM port, the Fetcher
// (resumable instruction bursts) and the LSB (1/2/4-byte loads and stores).
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | no transaction; arbitrate LSB, then fetch
// FETCH   | reading one 4-byte instruction
// LOAD    | reading 1/2/4 bytes for the LSB
// STORE   | writing 1/2/4 bytes for the LSB
// IO_WAIT | I/O store held until the I/O buffer has room
module memory_control #(
  parameter int         INST_BURST = 8,
  parameter logic [1:0] IO_HI      = 2'b11
) (
  input logic              clk_in,
  input logic              rst_in,
  memory_control_if.slave  bus
);

  localparam int CW = (INST_BURST > 1) ? $clog2(INST_BURST) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_STORE,
    S_IO_WAIT
  } state_t;

  state_t        state_q;
  logic          f_active_q;
  logic [31:0]   f_base_q;
  logic [CW-1:0] f_cnt_q;
  logic [31:0]   addr_q;
  logic [2:0]    size_q;
  logic [2:0]    idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   buf_q;
  logic          blk_fetch_q;
  logic          blk_lsb_q;

  logic [31:0]   mem_a_q;
  logic [7:0]    mem_dout_q;
  logic          mem_wr_q;
  logic          one_inst_q;
  logic          end_fetch_q;
  logic [31:0]   inst_q;
  logic          end_lsb_q;
  logic [31:0]   data_lsb_q;

  logic [31:0]   rd_word_d;
  logic [7:0]    wr_byte_d;
  logic [31:0]   fetch_addr_d;
  logic          lsb_go_d;
  logic          fetch_new_d;
  logic          lsb_io_wait_d;

  // Byte idx-2 arrives on mem_din at edge idx; buf_q was cleared at accept,
  // so OR-ing it in also zero-extends short loads.
  always_comb begin
    rd_word_d     = buf_q | ({24'd0, bus.mem_din} << {idx_q - 3'd2, 3'b000});
    wr_byte_d     = wdata_q[{idx_q[1:0], 3'b000} +: 8];
    fetch_addr_d  = f_base_q + 32'({f_cnt_q, 2'b00});
    lsb_go_d      = bus.enable_from_lsb && !blk_lsb_q &&
                    (bus.wr_flag_from_lsb || !bus.rollback_flag_from_rob);
    fetch_new_d   = bus.enable_from_fetcher && !f_active_q && !blk_fetch_q &&
                    !bus.reset_from_fetcher;
    lsb_io_wait_d = (bus.address_from_lsb[17:16] == IO_HI) && bus.io_buffer_full;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      f_active_q  <= 1'b0;
      f_base_q    <= '0;
      f_cnt_q     <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      blk_fetch_q <= 1'b0;
      blk_lsb_q   <= 1'b0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      one_inst_q  <= 1'b0;
      end_fetch_q <= 1'b0;
      inst_q      <= '0;
      end_lsb_q   <= 1'b0;
      data_lsb_q  <= '0;
    end else if (bus.rdy_in) begin
      one_inst_q  <= 1'b0;
      end_fetch_q <= 1'b0;
      end_lsb_q   <= 1'b0;

      if (bus.reset_from_fetcher) begin
        f_active_q <= 1'b0;
        f_cnt_q    <= '0;
      end

      case (state_q)
        S_IDLE: begin
          blk_fetch_q <= 1'b0;
          blk_lsb_q   <= 1'b0;
          if (lsb_go_d) begin
            addr_q  <= bus.address_from_lsb;
            size_q  <= bus.size_from_lsb;
            wdata_q <= bus.data_from_lsb;
            buf_q   <= '0;
            idx_q   <= 3'd1;
            if (!bus.wr_flag_from_lsb) begin
              state_q <= S_LOAD;
              mem_a_q <= bus.address_from_lsb;
            end else if (lsb_io_wait_d) begin
              state_q <= S_IO_WAIT;
            end else begin
              state_q    <= S_STORE;
              mem_wr_q   <= 1'b1;
              mem_a_q    <= bus.address_from_lsb;
              mem_dout_q <= bus.data_from_lsb[7:0];
            end
          end else if (f_active_q && !bus.reset_from_fetcher) begin
            state_q <= S_FETCH;
            addr_q  <= fetch_addr_d;
            mem_a_q <= fetch_addr_d;
            size_q  <= 3'd4;
            buf_q   <= '0;
            idx_q   <= 3'd1;
          end else if (fetch_new_d) begin
            state_q    <= S_FETCH;
            f_active_q <= 1'b1;
            f_base_q   <= bus.address_from_fetcher;
            f_cnt_q    <= '0;
            addr_q     <= bus.address_from_fetcher;
            mem_a_q    <= bus.address_from_fetcher;
            size_q     <= 3'd4;
            buf_q      <= '0;
            idx_q      <= 3'd1;
          end
        end

        S_FETCH, S_LOAD: begin
          if (state_q == S_FETCH && bus.reset_from_fetcher) begin
            state_q <= S_IDLE;
          end else if (state_q == S_LOAD && bus.rollback_flag_from_rob) begin
            state_q <= S_IDLE;
          end else begin
            if (idx_q < size_q) mem_a_q <= addr_q + 32'(idx_q);
            if (idx_q >= 3'd2) buf_q <= rd_word_d;
            idx_q <= idx_q + 3'd1;
            if (idx_q == size_q + 3'd1) begin
              state_q <= S_IDLE;
              if (state_q == S_FETCH) begin
                inst_q     <= rd_word_d;
                one_inst_q <= 1'b1;
                if (f_cnt_q == CW'(INST_BURST - 1)) begin
                  end_fetch_q <= 1'b1;
                  f_active_q  <= 1'b0;
                  f_cnt_q     <= '0;
                  blk_fetch_q <= 1'b1;
                end else begin
                  f_cnt_q <= f_cnt_q + 1'b1;
                end
              end else begin
                data_lsb_q <= rd_word_d;
                end_lsb_q  <= 1'b1;
                blk_lsb_q  <= 1'b1;
              end
            end
          end
        end

        S_STORE: begin
          if (idx_q < size_q) begin
            mem_a_q    <= addr_q + 32'(idx_q);
            mem_dout_q <= wr_byte_d;
            idx_q      <= idx_q + 3'd1;
          end else begin
            state_q   <= S_IDLE;
            mem_wr_q  <= 1'b0;
            end_lsb_q <= 1'b1;
            blk_lsb_q <= 1'b1;
          end
        end

        S_IO_WAIT: begin
          if (!bus.io_buffer_full) begin
            state_q    <= S_STORE;
            mem_wr_q   <= 1'b1;
            mem_a_q    <= addr_q;
            mem_dout_q <= wdata_q[7:0];
            idx_q      <= 3'd1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_a                      = mem_a_q;
  assign bus.mem_dout                   = mem_dout_q;
  assign bus.mem_wr                     = mem_wr_q;
  assign bus.one_inst_finish_to_fetcher = one_inst_q;
  assign bus.end_to_fetcher             = end_fetch_q;
  assign bus.inst_to_fetcher            = inst_q;
  assign bus.end_to_lsb                 = end_lsb_q;
  assign bus.data_to_lsb                = data_lsb_q;

endmodule

// File: tb/tb_memory_control.sv
// Scoreboard bench for memory_control: stimulus pushes expected pulses, a monitor pops them.
module tb_memory_control;
  logic clk = 1'b0;
  logic rst = 1'b0;
  memory_control_if bus();

  memory_control #(.INST_BURST(8), .IO_HI(2'b11)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] inst; logic last; } fexp_t;
  typedef struct { logic store; logic [31:0] data; } lexp_t;
  fexp_t fq[$];
  lexp_t lq[$];
  fexp_t fe;
  lexp_t le;

  logic [7:0] ram [0:262143];
  int checks = 0, errors = 0;
  int cyc = 0, wr_cnt = 0, io_wr_cnt = 0, fin_cnt = 0, lsb_end_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) ram[18'(a + 32'(k))] = w[8*k +: 8];
  endtask

  // which: 0 = end_to_fetcher, 1 = end_to_lsb; n = negedges taken
  task automatic wait_end(input int which, input int bound, input string nm, output int n);
    n = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if ((which == 0 && bus.end_to_fetcher) || (which == 1 && bus.end_to_lsb)) begin
        n = i;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: actual timeout after %0d cycles required end pulse", nm, bound);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.mem_din <= ram[bus.mem_a[17:0]];
    if (bus.mem_wr) begin
      ram[bus.mem_a[17:0]] <= bus.mem_dout;
      if (bus.mem_a == 32'h0003_0000) io_wr_cnt <= io_wr_cnt + 1;
    end
  end

  always @(negedge clk) if (bus.mem_wr) wr_cnt++;

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.one_inst_finish_to_fetcher) begin
        fin_cnt++;
        if (fq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_finish: actual inst %h required no pulse", bus.inst_to_fetcher);
        end else begin
          fe = fq.pop_front();
          chk("inst_to_fetcher", bus.inst_to_fetcher, fe.inst);
          chk("end_to_fetcher_flag", {31'd0, bus.end_to_fetcher}, {31'd0, fe.last});
        end
      end else if (bus.end_to_fetcher) begin
        checks++; errors++;
        $display("FAIL end_without_finish: actual end pulse 1 required 0");
      end
      if (bus.end_to_lsb) begin
        lsb_end_cnt++;
        if (lq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_end_to_lsb: actual pulse data %h required no pulse", bus.data_to_lsb);
        end else begin
          le = lq.pop_front();
          if (le.store) chk("store_end_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
          else          chk("data_to_lsb", bus.data_to_lsb, le.data);
        end
      end
    end
  end

  task automatic push_burst(input logic [31:0] base, input logic [31:0] w0);
    fexp_t e;
    for (int i = 0; i < 8; i++) begin
      put_word(base + 32'(4*i), w0 + 32'(i));
      e.inst = w0 + 32'(i);
      e.last = (i == 7);
      fq.push_back(e);
    end
  endtask

  task automatic run_burst(input logic [31:0] base, input logic [31:0] w0);
    int c0, wc0, f0, n;
    push_burst(base, w0);
    @(negedge clk);
    bus.address_from_fetcher = base;
    bus.enable_from_fetcher  = 1'b1;
    c0 = cyc; wc0 = wr_cnt; f0 = fin_cnt;
    wait_end(0, 100, "burst_end", n);
    bus.enable_from_fetcher = 1'b0;
    if (n != 0) chk("burst_edges", 32'(cyc - c0), 32'd48);
    @(negedge clk);
    chk("burst_finish_count", 32'(fin_cnt - f0), 32'd8);
    chk("burst_no_write", 32'(wr_cnt - wc0), 32'd0);
  endtask

  task automatic lsb_req(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    bus.wr_flag_from_lsb = wr;
    bus.address_from_lsb = a;
    bus.size_from_lsb    = sz;
    bus.data_from_lsb    = d;
    bus.enable_from_lsb  = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual time limit hit required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, f0, io0, bad, e0;
    lexp_t l;
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    bus.rdy_in = 1'b1; bus.io_buffer_full = 1'b0;
    bus.enable_from_fetcher = 1'b0; bus.address_from_fetcher = '0; bus.reset_from_fetcher = 1'b0;
    bus.enable_from_lsb = 1'b0; bus.wr_flag_from_lsb = 1'b0; bus.address_from_lsb = '0;
    bus.size_from_lsb = '0; bus.data_from_lsb = '0; bus.rollback_flag_from_rob = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
    chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("rst_pulses", {29'd0, bus.one_inst_finish_to_fetcher, bus.end_to_fetcher, bus.end_to_lsb}, 32'd0);
    chk("rst_inst", bus.inst_to_fetcher, 32'd0);
    chk("rst_data_to_lsb", bus.data_to_lsb, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain 8-instruction burst
    run_burst(32'h100, 32'h13);
    repeat (3) @(negedge clk);

    // LSB load raised during instruction 2 of a burst
    put_word(32'h200, 32'hDEAD_BEEF);
    push_burst(32'h400, 32'h20);
    l.store = 1'b0; l.data = 32'hDEAD_BEEF; lq.push_back(l);
    @(negedge clk);
    bus.address_from_fetcher = 32'h400; bus.enable_from_fetcher = 1'b1;
    f0 = fin_cnt;
    for (int i = 0; i < 40 && (fin_cnt - f0) < 2; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    lsb_req(1'b0, 32'h200, 3'd4, 32'd0);
    wait_end(1, 30, "interleave_lsb_end", n);
    bus.enable_from_lsb = 1'b0;
    chk("interleave_order", 32'(fin_cnt - f0), 32'd3);
    wait_end(0, 100, "interleave_burst_end", n);
    bus.enable_from_fetcher = 1'b0;
    @(negedge clk);
    chk("interleave_finish_count", 32'(fin_cnt - f0), 32'd8);
    repeat (3) @(negedge clk);

    // Store size 2 at an odd address
    ram[18'h301] = 8'h00; ram[18'h302] = 8'h00; ram[18'h303] = 8'h77;
    l.store = 1'b1; l.data = '0; lq.push_back(l);
    lsb_req(1'b1, 32'h301, 3'd2, 32'hA1B2_C3D4);
    wait_end(1, 10, "store2_end", n);
    bus.enable_from_lsb = 1'b0;
    chk("store2_latency", 32'(n), 32'd3);
    @(negedge clk);
    chk("store2_b0", {24'd0, ram[18'h301]}, 32'hD4);
    chk("store2_b1", {24'd0, ram[18'h302]}, 32'hC3);
    chk("store2_b2_untouched", {24'd0, ram[18'h303]}, 32'h77);
    repeat (2) @(negedge clk);

    // I/O store held while the buffer is full
    bus.io_buffer_full = 1'b1;
    l.store = 1'b1; lq.push_back(l);
    io0 = io_wr_cnt; bad = 0;
    lsb_req(1'b1, 32'h0003_0000, 3'd1, 32'h41);
    repeat (6) begin @(negedge clk); if (bus.mem_wr) bad++; end
    bus.io_buffer_full = 1'b0;
    chk("io_hold_no_write", 32'(bad), 32'd0);
    @(negedge clk);
    chk("io_first_free_wr", {31'd0, bus.mem_wr}, 32'd1);
    chk("io_first_free_addr", bus.mem_a, 32'h0003_0000);
    wait_end(1, 10, "io_end", n);
    bus.enable_from_lsb = 1'b0;
    repeat (2) @(negedge clk);
    chk("io_byte", {24'd0, ram[18'h30000]}, 32'h41);
    chk("io_write_count", 32'(io_wr_cnt - io0), 32'd1);

    // Fetcher reset mid-instruction, then a new base
    bus.address_from_fetcher = 32'h500; bus.enable_from_fetcher = 1'b1;
    f0 = fin_cnt;
    repeat (3) @(negedge clk);
    push_burst(32'h600, 32'h40);
    bus.reset_from_fetcher = 1'b1; bus.address_from_fetcher = 32'h600;
    @(negedge clk);
    bus.reset_from_fetcher = 1'b0;
    chk("abort_no_pulse", 32'(fin_cnt - f0), 32'd0);
    @(negedge clk);
    chk("abort_new_base", bus.mem_a, 32'h600);
    wait_end(0, 100, "abort_burst_end", n);
    bus.enable_from_fetcher = 1'b0;
    @(negedge clk);
    chk("abort_finish_count", 32'(fin_cnt - f0), 32'd8);
    repeat (2) @(negedge clk);

    // Rollback during a load
    e0 = lsb_end_cnt;
    lsb_req(1'b0, 32'h200, 3'd4, 32'd0);
    repeat (2) @(negedge clk);
    bus.rollback_flag_from_rob = 1'b1; bus.enable_from_lsb = 1'b0;
    @(negedge clk);
    bus.rollback_flag_from_rob = 1'b0;
    repeat (10) @(negedge clk);
    chk("rollback_load_no_end", 32'(lsb_end_cnt - e0), 32'd0);

    // Rollback during a store
    l.store = 1'b1; lq.push_back(l);
    lsb_req(1'b1, 32'h310, 3'd4, 32'h1122_3344);
    @(negedge clk);
    bus.rollback_flag_from_rob = 1'b1;
    @(negedge clk);
    bus.rollback_flag_from_rob = 1'b0;
    wait_end(1, 10, "rollback_store_end", n);
    bus.enable_from_lsb = 1'b0;
    @(negedge clk);
    chk("rollback_store_word", {ram[18'h313], ram[18'h312], ram[18'h311], ram[18'h310]}, 32'h1122_3344);
    repeat (2) @(negedge clk);

    // Async reset in the middle of a store
    lsb_req(1'b1, 32'h320, 3'd4, 32'h5566_7788);
    @(negedge clk);
    chk("prereset_store_active", {31'd0, bus.mem_wr}, 32'd1);
    rst = 1'b1;
    bus.enable_from_lsb = 1'b0;
    #1;
    chk("async_rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("async_rst_mem_a", bus.mem_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_burst(32'h100, 32'h13);
    repeat (3) @(negedge clk);
    chk("queues_drained", 32'(fq.size() + lq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
